// File: rtl/bass_eq_pkg.sv
// Shared widths, FSM state type and default coefficient table for the bass EQ chain.
// The saturation helper turns a Q-format accumulator into a clamped output sample.
package bass_eq_pkg;

  localparam int TAPS      = 16;
  localparam int SAMPLE_W  = 16;
  localparam int OUT_W     = 20;
  localparam int ACC_W     = 36;
  localparam int COEF_W    = 16;
  localparam int FRAC_BITS = COEF_W - 1;

  // Moving average: every tap is 1/16 in Q1.15, so the taps sum to unity gain.
  localparam logic [TAPS*COEF_W-1:0] DEFAULT_COEFS = {TAPS{16'h0800}};

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    OUT
  } fir_state_t;

  // Floor-shift out the fraction bits, then clamp to the output range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> FRAC_BITS;
    if (shifted > OUT_MAX) begin
      shifted = OUT_MAX;
    end else if (shifted < OUT_MIN) begin
      shifted = OUT_MIN;
    end
    return shifted[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/bass_coef_rom.sv
// Combinational coefficient lookup for the bass FIR, one 16-bit Q1.15 word per tap.
module bass_coef_rom
  import bass_eq_pkg::*;
(
  input  logic [3:0]  addr,
  output logic [15:0] coef
);

  assign coef = DEFAULT_COEFS[addr*COEF_W +: COEF_W];

endmodule

// File: rtl/bass_fir_mac.sv
// 16-tap FIR low-pass for the bass path, computed with a single multiply-accumulate
// per clock over a circular sample history.
module bass_fir_mac
  import bass_eq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inSample,
  input  logic        RDYsample,
  output logic [19:0] outBass,
  output logic        RDYaddbass,
  output logic        busy,
  output logic        overrun
);

  fir_state_t state_reg, state_next;

  logic [3:0]                     ptr_reg;
  logic [3:0]                     tap_reg;
  logic signed [ACC_W-1:0]        acc_reg;
  logic signed [OUT_W-1:0]        out_bass_reg;
  logic                           rdy_reg;
  logic                           overrun_reg;

  logic signed [SAMPLE_W-1:0]     hist [TAPS];
  logic [3:0]                     rd_idx;
  logic [COEF_W-1:0]              coef;
  logic signed [2*SAMPLE_W-1:0]   prod;
  logic signed [ACC_W-1:0]        prod_ext;

  // History registers are individually reset so unwritten taps contribute zero.
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_hist
      logic signed [SAMPLE_W-1:0] sample_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sample_reg <= '0;
        end else if (state_reg == LOAD && ptr_reg == 4'(gi)) begin
          sample_reg <= inSample;
        end
      end
      assign hist[gi] = sample_reg;
    end
  endgenerate

  // ptr_reg points at the newest sample throughout MAC, so x[n-k] sits at ptr-k.
  assign rd_idx   = ptr_reg - tap_reg;
  assign prod     = 32'($signed(coef)) * 32'(hist[rd_idx]);
  assign prod_ext = ACC_W'(prod);

  bass_coef_rom u_coef_rom (
    .addr (tap_reg),
    .coef (coef)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (RDYsample) state_next = LOAD;
      LOAD:    state_next = MAC;
      MAC:     if (tap_reg == 4'(TAPS - 1)) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      tap_reg      <= '0;
      acc_reg      <= '0;
      out_bass_reg <= '0;
      rdy_reg      <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      rdy_reg <= 1'b0;
      // A strobe seen in OUT is still a busy-time strobe and is dropped.
      if (RDYsample && state_reg != IDLE) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        LOAD: begin
          acc_reg <= '0;
          tap_reg <= '0;
        end
        MAC: begin
          acc_reg <= acc_reg + prod_ext;
          tap_reg <= tap_reg + 4'd1;
        end
        OUT: begin
          out_bass_reg <= sat_out(acc_reg);
          rdy_reg      <= 1'b1;
          ptr_reg      <= ptr_reg + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign outBass    = out_bass_reg;
  assign RDYaddbass = rdy_reg;
  assign busy       = (state_reg != IDLE);
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_bass_fir_mac.sv
// Directed-vector bench for bass_fir_mac: impulse, DC, full-scale, overrun, reset and timing.
module tb_bass_fir_mac;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] inSample;
  logic               RDYsample;
  logic signed [19:0] outBass;
  logic               RDYaddbass;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  bass_fir_mac dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inSample   (inSample),
    .RDYsample  (RDYsample),
    .outBass    (outBass),
    .RDYaddbass (RDYaddbass),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    RDYsample = 1'b0;
    inSample = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Strobe one sample and wait (bounded) for the result pulse; lat=-1 on timeout.
  task automatic send_sample(input logic signed [15:0] s, output int lat, output int res);
    @(negedge clk);
    inSample = s;
    RDYsample = 1'b1;
    @(posedge clk);
    #1;
    RDYsample = 1'b0;
    lat = -1;
    res = 32'h7fffffff;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (RDYaddbass) begin
        lat = n;
        res = int'(outBass);
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (outBass !== 20'sd0 || RDYaddbass !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: outBass=%0d rdy=%b busy=%b overrun=%b required 0 0 0 0",
               outBass, RDYaddbass, busy, overrun);
    end
    $display("reset: outBass=%0d rdy=%b busy=%b overrun=%b", outBass, RDYaddbass, busy, overrun);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_impulse();
    int lat, res, exp;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exp = (i < 16) ? 2047 : 0;
      send_sample((i == 0) ? 16'sd32767 : 16'sd0, lat, res);
      $display("impulse[%0d]: latency=%0d outBass=%0d expected=%0d", i, lat, res, exp);
      checks++;
      if (lat !== 18) begin
        errors++;
        $display("FAIL impulse_latency[%0d]: got %0d required 18", i, lat);
      end
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL impulse_value[%0d]: got %0d required %0d", i, res, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (RDYaddbass !== 1'b0 || int'(outBass) !== exp) begin
        errors++;
        $display("FAIL impulse_pulse_hold[%0d]: rdy=%b outBass=%0d required 0 %0d",
                 i, RDYaddbass, outBass, exp);
      end
    end
  endtask

  task automatic test_dc();
    int lat, res, exp;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      exp = (1000 * ((i < 16) ? (i + 1) : 16)) / 16;
      send_sample(16'sd1000, lat, res);
      $display("dc[%0d]: latency=%0d outBass=%0d expected=%0d", i, lat, res, exp);
      checks++;
      if (lat !== 18 || res !== exp) begin
        errors++;
        $display("FAIL dc[%0d]: got latency=%0d value=%0d required 18 %0d", i, lat, res, exp);
      end
    end
  endtask

  task automatic test_neg_full();
    int lat, res, exp;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      exp = -2048 * ((i < 16) ? (i + 1) : 16);
      send_sample(-16'sd32768, lat, res);
      $display("negfs[%0d]: latency=%0d outBass=%0d expected=%0d", i, lat, res, exp);
      checks++;
      if (lat !== 18 || res !== exp) begin
        errors++;
        $display("FAIL negfs[%0d]: got latency=%0d value=%0d required 18 %0d", i, lat, res, exp);
      end
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL negfs_overrun: got %b required 0", overrun);
    end
  endtask

  // Second strobe 5 clocks after the first must be dropped and flag overrun.
  task automatic test_overrun();
    int pulses, first_edge, first_val, lat, res;
    do_reset();
    pulses = 0;
    first_edge = -1;
    first_val = 0;
    @(negedge clk);
    inSample = 16'sd32767;
    RDYsample = 1'b1;
    @(posedge clk);
    #1;
    RDYsample = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (RDYaddbass) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = e;
          first_val = int'(outBass);
        end
      end
      if (e == 4) begin
        inSample = 16'sd1000;
        RDYsample = 1'b1;
      end else begin
        RDYsample = 1'b0;
      end
    end
    $display("overrun: pulses=%0d first_edge=%0d outBass=%0d overrun=%b", pulses, first_edge, first_val, overrun);
    checks++;
    if (pulses !== 1 || first_edge !== 18) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d at edge %0d required 1 at 18", pulses, first_edge);
    end
    checks++;
    if (first_val !== 2047) begin
      errors++;
      $display("FAIL overrun_value: got %0d required 2047", first_val);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got %b required 1", overrun);
    end
    send_sample(16'sd0, lat, res);
    $display("overrun_followup: latency=%0d outBass=%0d overrun=%b", lat, res, overrun);
    checks++;
    if (overrun !== 1'b1 || res !== 2047 || lat !== 18) begin
      errors++;
      $display("FAIL overrun_sticky: got overrun=%b value=%0d latency=%0d required 1 2047 18",
               overrun, res, lat);
    end
  endtask

  // Strobe during OUT is dropped; the strobe one cycle later is accepted.
  task automatic test_back_to_back();
    int pulse_edges[$];
    int vals[$];
    do_reset();
    @(negedge clk);
    inSample = 16'sd32767;
    RDYsample = 1'b1;
    @(posedge clk);
    #1;
    RDYsample = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      if (RDYaddbass) begin
        pulse_edges.push_back(e);
        vals.push_back(int'(outBass));
      end
      if (e == 17 || e == 18) begin
        inSample = 16'sd1000;
        RDYsample = 1'b1;
      end else begin
        RDYsample = 1'b0;
      end
    end
    $display("back_to_back: pulses=%0d overrun=%b", pulse_edges.size(), overrun);
    checks++;
    if (pulse_edges.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses required 2", pulse_edges.size());
    end else begin
      $display("back_to_back: edges=%0d,%0d values=%0d,%0d", pulse_edges[0], pulse_edges[1], vals[0], vals[1]);
      checks++;
      if (pulse_edges[0] !== 18 || pulse_edges[1] !== 37) begin
        errors++;
        $display("FAIL b2b_timing: got %0d,%0d required 18,37", pulse_edges[0], pulse_edges[1]);
      end
      checks++;
      if (vals[0] !== 2047 || vals[1] !== 2110) begin
        errors++;
        $display("FAIL b2b_values: got %0d,%0d required 2047,2110", vals[0], vals[1]);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overrun: got %b required 1", overrun);
    end
  endtask

  task automatic test_reset_mid_mac();
    int pulses, lat, res;
    do_reset();
    @(negedge clk);
    inSample = 16'sd32767;
    RDYsample = 1'b1;
    @(posedge clk);
    #1;
    RDYsample = 1'b0;
    pulses = 0;
    repeat (11) begin
      @(posedge clk);
      #1;
      if (RDYaddbass) pulses++;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (RDYaddbass) pulses++;
    end
    $display("reset_mid_mac: pulses=%0d outBass=%0d busy=%b", pulses, outBass, busy);
    checks++;
    if (pulses !== 0 || outBass !== 20'sd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mac: pulses=%0d outBass=%0d busy=%b required 0 0 0", pulses, outBass, busy);
    end
    send_sample(16'sd32767, lat, res);
    $display("reset_mid_mac_next: latency=%0d outBass=%0d", lat, res);
    checks++;
    if (lat !== 18 || res !== 2047) begin
      errors++;
      $display("FAIL reset_mid_mac_next: got latency=%0d value=%0d required 18 2047", lat, res);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    RDYsample = 1'b0;
    inSample = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_impulse();
    test_dc();
    test_neg_full();
    test_overrun();
    test_back_to_back();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
